// File: rtl/boot_loader.sv
// Boot loader: streams instruction words into instruction memory until the
// end-of-program sentinel, then releases the control unit from reset.
module boot_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic              overflow,
    output logic [2:0]        dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready depends on state only (high exactly in LOAD).
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t state;
    state_t state_next;
    logic   is_end;
    logic   full;
    logic   do_write;

    assign is_end    = (in_data == END_WORD);
    assign full      = (words_loaded == CAPACITY);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_reset  = 1'b1;
        boot_done  = 1'b0;
        overflow   = 1'b0;
        do_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_end)    state_next = S_RELEASE;
                    else if (full) state_next = S_ERROR;
                    else           do_write   = 1'b1;
                end
            end
            // One extra cycle in reset lets the last registered write retire.
            S_RELEASE: state_next = S_DONE;
            S_DONE: begin
                cpu_reset = 1'b0;
                boot_done = 1'b1;
            end
            S_ERROR: overflow = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            state  <= state_next;
            mem_we <= do_write;
            if (do_write) begin
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= in_data;
                words_loaded <= words_loaded + 1'b1;
            end
            if (state == S_IDLE && start) words_loaded <= '0;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader (ADDR_W=2): per-cycle vector table, directed
// corner sequences and random sessions checked against a session-level model.
module tb_boot_loader;

    localparam int          AW   = 2;
    localparam int          CAP  = 1 << AW;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, mem_we, cpu_reset, boot_done, overflow;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   words_loaded;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    prog[8];

    boot_loader #(.ADDR_W(AW), .END_WORD(ENDW)) dut (
        .clock(clk), .reset(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .words_loaded(words_loaded),
        .cpu_reset(cpu_reset), .boot_done(boot_done), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every observed write must be the next one the model predicted.
    always @(posedge clk) begin
        #1;
        if (mon_en && mem_we === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_write", {63'd0, mem_we}, 64'd0);
            else check("write_addr_data", {30'd0, mem_addr, mem_wdata}, {30'd0, exp_q.pop_front()});
        end
    end

    typedef struct {
        logic          rst, start, vld;
        logic [31:0]   data;
        logic          rdy, we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [AW:0]   wl;
        logic          cpu, done, ovf;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic r, s, v, input logic [31:0] d,
                                input logic rdy, we, input logic [AW-1:0] a,
                                input logic [31:0] wd, input logic [AW:0] wl,
                                input logic cpu, done, ovf);
        vec_t t;
        t.rst = r; t.start = s; t.vld = v; t.data = d;
        t.rdy = rdy; t.we = we; t.addr = a; t.wdata = wd; t.wl = wl;
        t.cpu = cpu; t.done = done; t.ovf = ovf;
        return t;
    endfunction

    function automatic logic [63:0] outs();
        return {22'd0, in_ready, mem_we, mem_addr, mem_wdata, words_loaded, cpu_reset, boot_done, overflow};
    endfunction

    task automatic pulse_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Model: the first CAP data words are written to addresses 0.. in order;
    // an (n <= CAP) program ends in DONE with n words, a longer one in ERROR.
    task automatic run_session(input int n, input int gap_min, input int gap_max);
        int sent = 0;
        pulse_reset();
        check("reset_clears_out", outs(), {22'd0, 1'b0, 1'b0, {AW{1'b0}}, 32'd0, {(AW+1){1'b0}}, 3'b100});
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < n && i <= CAP; i++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin
                in_valid = 1'b0;
                step();
                check("gap_no_release", {62'd0, in_ready, boot_done}, 64'b10);
                check("gap_no_write", {63'd0, mem_we}, 64'd0);
            end
            in_valid = 1'b1;
            in_data  = prog[i];
            if (i < CAP) exp_q.push_back({i[AW-1:0], prog[i]});
            step();
            sent++;
        end
        in_valid = 1'b0;
        if (n <= CAP) begin
            in_valid = 1'b1;
            in_data  = ENDW;
            step();
            in_valid = 1'b0;
            check("release_state", {59'd0, in_ready, cpu_reset, boot_done, overflow, mem_we}, {59'd0, 5'b01000});
            check("release_count", {61'd0, words_loaded}, 64'(n));
            step();
            check("done_state", {60'd0, in_ready, cpu_reset, boot_done, overflow}, {60'd0, 4'b0010});
            start = 1'b1;
            step();
            start = 1'b0;
            check("done_holds", {57'd0, words_loaded, cpu_reset, boot_done, overflow, mem_we}, {57'd0, 3'(n), 4'b0100});
        end else begin
            check("error_state", {60'd0, in_ready, cpu_reset, boot_done, overflow}, {60'd0, 4'b0101});
            check("error_count", {61'd0, words_loaded}, 64'(CAP));
            start = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
            step(); step();
            start = 1'b0; in_valid = 1'b0;
            check("error_holds", {57'd0, words_loaded, in_ready, cpu_reset, boot_done, overflow}, {57'd0, 3'(CAP), 4'b0101});
        end
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vecs[0]  = mk(1,0,0,32'h0,        0,0,0,32'h0,        0,1,0,0);
        vecs[1]  = mk(0,1,0,32'h0,        1,0,0,32'h0,        0,1,0,0);
        vecs[2]  = mk(0,0,1,32'h0000_0013,1,1,0,32'h0000_0013,1,1,0,0);
        vecs[3]  = mk(0,0,1,32'h00A0_0093,1,1,1,32'h00A0_0093,2,1,0,0);
        vecs[4]  = mk(0,0,1,32'h0000_0073,1,1,2,32'h0000_0073,3,1,0,0);
        vecs[5]  = mk(0,0,1,ENDW,         0,0,2,32'h0000_0073,3,1,0,0);
        vecs[6]  = mk(0,0,0,32'h0,        0,0,2,32'h0000_0073,3,0,1,0);
        vecs[7]  = mk(0,1,0,32'h0,        0,0,2,32'h0000_0073,3,0,1,0);
        vecs[8]  = mk(0,0,1,32'h5,        0,0,2,32'h0000_0073,3,0,1,0);
        vecs[9]  = mk(1,0,0,32'h0,        0,0,0,32'h0,        0,1,0,0);
        vecs[10] = mk(0,0,1,32'h55,       0,0,0,32'h0,        0,1,0,0);
        vecs[11] = mk(0,1,1,32'h55,       1,0,0,32'h0,        0,1,0,0);
        vecs[12] = mk(0,0,1,ENDW,         0,0,0,32'h0,        0,1,0,0);
        vecs[13] = mk(0,0,0,32'h0,        0,0,0,32'h0,        0,0,1,0);

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; start = vecs[i].start;
            in_valid = vecs[i].vld; in_data = vecs[i].data;
            step();
            check($sformatf("vec%0d", i), outs(),
                  {22'd0, vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].wl, vecs[i].cpu, vecs[i].done, vecs[i].ovf});
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        mon_en = 1'b1;

        // Same program with 5-cycle gaps between words.
        prog[0] = 32'h0000_0013; prog[1] = 32'h00A0_0093; prog[2] = 32'h0000_0073;
        run_session(3, 5, 5);

        // Full memory, then one word too many.
        for (int i = 0; i < 8; i++) prog[i] = 32'h1000_0000 + i;
        run_session(CAP, 0, 0);
        run_session(CAP + 1, 0, 0);
        run_session(0, 0, 0);

        // Reset after 2 of 3 words: no further writes, reload starts at 0.
        pulse_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = prog[i];
            exp_q.push_back({i[AW-1:0], prog[i]});
            step();
        end
        rst = 1'b1; in_data = prog[2];
        step();
        check("midload_reset", outs(), {22'd0, 1'b0, 1'b0, {AW{1'b0}}, 32'd0, {(AW+1){1'b0}}, 3'b100});
        rst = 1'b0;
        repeat (3) begin
            step();
            check("after_abort_idle", {62'd0, in_ready, mem_we}, 64'd0);
        end
        in_valid = 1'b0;
        check("abort_writes_drained", 64'(exp_q.size()), 64'd0);
        run_session(3, 0, 0);

        for (int s = 0; s < 30; s++) begin
            int n;
            n = $urandom_range(CAP + 2, 0);
            for (int i = 0; i < 8; i++) begin
                prog[i] = $urandom;
                if (prog[i] == ENDW) prog[i] = 32'h0;
            end
            run_session(n, 0, $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
